pdes_sched_ctrl: RTL

//  Parametrised PHOLD-style scheduler controller for the PDES engine; NUM_CORES-wide generalisation of the 4-core top.

---
 rtl/pdes_sched_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pdes_sched_ctrl.sv
// PHOLD-style PDES scheduler control: queue seeding, receive/dispatch
// arbitration, per-core in-flight tracking, GVT and termination.
module pdes_sched_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int TIME_W    = 13,
    parameter int LP_W      = 3,
    parameter int N_INIT    = 4,
    parameter int QCNT_W    = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [TIME_W-1:0]                end_time,
    output logic [TIME_W-1:0]                gvt,
    output logic                             busy,
    output logic                             done,
    input  logic [NUM_CORES-1:0]             core_ready,
    output logic [NUM_CORES-1:0]             core_evt_vld,
    output logic [TIME_W+LP_W-1:0]           core_evt_data,
    input  logic [NUM_CORES-1:0]             core_new_vld,
    input  logic [NUM_CORES*(TIME_W+LP_W)-1:0] core_new_data,
    output logic [NUM_CORES-1:0]             core_new_ack,
    output logic                             q_enq,
    output logic                             q_deq,
    output logic [TIME_W+LP_W-1:0]           q_enq_data,
    input  logic [TIME_W+LP_W-1:0]           q_head,
    input  logic [QCNT_W-1:0]                q_count,
    input  logic                             q_full
);

    localparam int EV_W = TIME_W + LP_W;
    localparam int IW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CW   = 8;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_FIN} state_e;

    state_e              state_q, state_d;
    logic [TIME_W-1:0]   gvt_q, gvt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_CORES-1:0] act_q, act_d;
    logic [TIME_W-1:0]   loc_q [NUM_CORES];
    logic [TIME_W-1:0]   loc_d [NUM_CORES];
    logic [IW-1:0]       rxp_q, rxp_d, txp_q, txp_d;
    logic [CW-1:0]       icnt_q, icnt_d;

    logic                rx_hit, tx_hit, cand_vld;
    logic [IW-1:0]       rx_g, tx_g;
    logic [TIME_W-1:0]   cand, head_t;

    // Round-robin search starting at ptr; returns {hit, index}
    function automatic logic [IW:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                            input logic [IW-1:0] ptr);
        logic [IW:0] r;
        int j;
        r = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            j = (int'(ptr) + k) % NUM_CORES;
            if (!r[IW] && req[j]) r = {1'b1, IW'(j)};
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
        return (int'(g) == NUM_CORES - 1) ? '0 : g + 1'b1;
    endfunction

    assign head_t = q_head[EV_W-1:LP_W];
    assign {rx_hit, rx_g} = rr_pick(core_new_vld, rxp_q);
    assign {tx_hit, tx_g} = rr_pick(core_ready, txp_q);

    always_comb begin
        cand_vld = (q_count != '0);
        cand     = head_t;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (act_q[i] && (!cand_vld || loc_q[i] < cand)) begin
                cand_vld = 1'b1;
                cand     = loc_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gvt_d        = gvt_q;
        act_d        = act_q;
        loc_d        = loc_q;
        rxp_d        = rxp_q;
        txp_d        = txp_q;
        icnt_d       = icnt_q;
        q_enq        = 1'b0;
        q_deq        = 1'b0;
        q_enq_data   = '0;
        core_evt_vld = '0;
        core_new_ack = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    gvt_d   = '0;
                    icnt_d  = '0;
                end
            end
            S_INIT: begin
                if (!q_full) begin
                    q_enq      = 1'b1;
                    q_enq_data = {TIME_W'(0), LP_W'(icnt_q)};
                    icnt_d     = icnt_q + 1'b1;
                    if (icnt_q == CW'(N_INIT - 1)) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rx_hit && !q_full) begin
                    core_new_ack[rx_g] = 1'b1;
                    q_enq              = 1'b1;
                    q_enq_data         = core_new_data[int'(rx_g)*EV_W +: EV_W];
                    act_d[rx_g]        = 1'b0;
                    rxp_d              = rr_next(rx_g);
                end else if (q_count != '0 && tx_hit) begin
                    core_evt_vld[tx_g] = 1'b1;
                    q_deq              = 1'b1;
                    act_d[tx_g]        = 1'b1;
                    loc_d[tx_g]        = head_t;
                    txp_d              = rr_next(tx_g);
                end
                // GVT is monotonic even if a straggler lands below it
                if (cand_vld && cand >= gvt_q) gvt_d = cand;
                if (gvt_q > end_time ||
                    (act_q == '0 && q_count == '0 && core_new_vld == '0))
                    state_d = S_FIN;
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_q == S_RUN) && (state_d == S_FIN);
        busy_d = (state_d == S_INIT) || (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gvt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            act_q   <= '0;
            rxp_q   <= '0;
            txp_q   <= '0;
            icnt_q  <= '0;
            for (int i = 0; i < NUM_CORES; i++) loc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            gvt_q   <= gvt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            act_q   <= act_d;
            rxp_q   <= rxp_d;
            txp_q   <= txp_d;
            icnt_q  <= icnt_d;
            loc_q   <= loc_d;
        end
    end

    assign gvt           = gvt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign core_evt_data = q_head;

endmodule
